// File: rtl/hazard_forwarding_unit.sv
// RAW-hazard resolution for the 5-stage pipeline: registered forwarding selects, load-use stall, flush, freeze.
// Optional macro HAZARD_FORWARDING_EN enables forwarding; without it every RAW dependency stalls.
module hazard_forwarding_unit #(
  parameter int unsigned REG_ADDR_WIDTH    = 5,
  parameter int unsigned STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_ADDR_WIDTH-1:0]    idRsInput,
  input  logic [REG_ADDR_WIDTH-1:0]    idRtInput,
  input  logic                         exRegWriteInput,
  input  logic                         exMemReadInput,
  input  logic [REG_ADDR_WIDTH-1:0]    exRegWriteRegisterInput,
  input  logic                         branchControlInput,
  input  logic                         memBusyInput,
  output logic [1:0]                   forwardingMux0Output,
  output logic [1:0]                   forwardingMux1Output,
  output logic                         stallOutput,
  output logic                         bubbleOutput,
  output logic                         flushOutput,
  output logic                         freezeOutput,
  output logic [STALL_COUNT_WIDTH-1:0] stallCountOutput
);

  localparam logic [1:0]                   SEL_RF    = 2'd0;
  localparam logic [1:0]                   SEL_MEM   = 2'd1;
  localparam logic [1:0]                   SEL_WB    = 2'd2;
  localparam logic [REG_ADDR_WIDTH-1:0]    REG_ZERO  = '0;
  localparam logic [STALL_COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Shadow of the producer that has just moved from EX into MEM
  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_dest;

  logic       ex_rs_match;
  logic       ex_rt_match;
  logic       mem_rs_match;
  logic       mem_rt_match;
  logic       hazard;
  logic [1:0] rs_sel_next;
  logic [1:0] rt_sel_next;

  // Register $0 and non-writing producers never match
  always_comb begin
    ex_rs_match  = exRegWriteInput && (exRegWriteRegisterInput != REG_ZERO) &&
                   (exRegWriteRegisterInput == idRsInput);
    ex_rt_match  = exRegWriteInput && (exRegWriteRegisterInput != REG_ZERO) &&
                   (exRegWriteRegisterInput == idRtInput);
    mem_rs_match = mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == idRsInput);
    mem_rt_match = mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == idRtInput);
  end

`ifdef HAZARD_FORWARDING_EN
  assign hazard = exMemReadInput && (ex_rs_match || ex_rt_match);

  // Newest producer wins: EX (moving to MEM) over the shadow MEM (moving to WB)
  always_comb begin
    rs_sel_next = SEL_RF;
    rt_sel_next = SEL_RF;
    if (ex_rs_match)       rs_sel_next = SEL_MEM;
    else if (mem_rs_match) rs_sel_next = SEL_WB;
    if (ex_rt_match)       rt_sel_next = SEL_MEM;
    else if (mem_rt_match) rt_sel_next = SEL_WB;
  end
`else
  logic unused_mem_read;
  assign unused_mem_read = exMemReadInput;
  assign hazard          = ex_rs_match || ex_rt_match || mem_rs_match || mem_rt_match;
  assign rs_sel_next     = SEL_RF;
  assign rt_sel_next     = SEL_RF;
`endif

  // Priority: freeze > flush > stall
  always_comb begin
    freezeOutput = memBusyInput;
    flushOutput  = branchControlInput && !memBusyInput;
    stallOutput  = hazard && !flushOutput && !memBusyInput;
    bubbleOutput = stallOutput;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_reg_write        <= 1'b0;
      mem_dest             <= REG_ZERO;
      forwardingMux0Output <= SEL_RF;
      forwardingMux1Output <= SEL_RF;
    end else if (!memBusyInput) begin
      mem_reg_write <= exRegWriteInput;
      mem_dest      <= exRegWriteRegisterInput;
      if (flushOutput || stallOutput) begin
        forwardingMux0Output <= SEL_RF;
        forwardingMux1Output <= SEL_RF;
      end else begin
        forwardingMux0Output <= rs_sel_next;
        forwardingMux1Output <= rt_sel_next;
      end
    end
  end

  // Saturating count of stall and freeze cycles; flushes are not counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCountOutput <= '0;
    end else if ((stallOutput || freezeOutput) && (stallCountOutput != COUNT_MAX)) begin
      stallCountOutput <= stallCountOutput + STALL_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Self-checking bench for hazard_forwarding_unit: directed scenarios plus random traffic against a reference model.
module tb_hazard_forwarding_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs = '0, rt = '0, ex_dest = '0;
  logic          ex_we = 1'b0, ex_mr = 1'b0, br = 1'b0, busy = 1'b0;
  logic [1:0]    sel0, sel1;
  logic          stall, bubble, flush, freeze;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  // Reference state: destination now in MEM (0 = none, since $0 never matches), selects, count
  int m_mem_prod;
  int m_sel0, m_sel1, m_cnt;
  int e_stall, e_flush, e_freeze;

  always #5 clk = ~clk;

  hazard_forwarding_unit #(.REG_ADDR_WIDTH(AW), .STALL_COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .idRsInput(rs), .idRtInput(rt),
    .exRegWriteInput(ex_we), .exMemReadInput(ex_mr),
    .exRegWriteRegisterInput(ex_dest),
    .branchControlInput(br), .memBusyInput(busy),
    .forwardingMux0Output(sel0), .forwardingMux1Output(sel1),
    .stallOutput(stall), .bubbleOutput(bubble), .flushOutput(flush),
    .freezeOutput(freeze), .stallCountOutput(cnt)
  );

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int ex_prod();
    return ex_we ? int'(ex_dest) : 0;
  endfunction

  function automatic bit depends(input int src, input int prod);
    return (prod != 0) && (prod == src);
  endfunction

  function automatic int fwd_sel(input int src);
`ifdef HAZARD_FORWARDING_EN
    if (depends(src, ex_prod())) return 1;
    if (depends(src, m_mem_prod)) return 2;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_mem_prod = 0; m_sel0 = 0; m_sel1 = 0; m_cnt = 0;
  endtask

  // Expected combinational controls for the current inputs
  task automatic model_comb();
    bit ex_dep, mem_dep, hz;
    ex_dep  = depends(int'(rs), ex_prod()) || depends(int'(rt), ex_prod());
    mem_dep = depends(int'(rs), m_mem_prod) || depends(int'(rt), m_mem_prod);
`ifdef HAZARD_FORWARDING_EN
    hz = ex_mr && ex_dep;
`else
    hz = ex_dep || mem_dep;
`endif
    e_freeze = busy ? 1 : 0;
    e_flush  = (br && !busy) ? 1 : 0;
    e_stall  = (hz && !e_flush && !busy) ? 1 : 0;
  endtask

  // One clock: check controls mid-cycle, advance model at the edge, check registers after
  task automatic cycle();
    #1;
    model_comb();
    check("stall",  int'(stall),  e_stall);
    check("bubble", int'(bubble), e_stall);
    check("flush",  int'(flush),  e_flush);
    check("freeze", int'(freeze), e_freeze);
    @(posedge clk);
    if (!busy) begin
      if (e_flush != 0 || e_stall != 0) begin
        m_sel0 = 0; m_sel1 = 0;
      end else begin
        m_sel0 = fwd_sel(int'(rs));
        m_sel1 = fwd_sel(int'(rt));
      end
      m_mem_prod = ex_prod();
    end
    if ((e_stall != 0 || e_freeze != 0) && m_cnt < CNT_MAX) m_cnt++;
    #1;
    check("sel0",  int'(sel0), m_sel0);
    check("sel1",  int'(sel1), m_sel1);
    check("count", int'(cnt),  m_cnt);
  endtask

  task automatic drive(input int r_s, input int r_t, input bit we, input bit mr,
                       input int dst, input bit b, input bit bz);
    rs = AW'(r_s); rt = AW'(r_t); ex_we = we; ex_mr = mr;
    ex_dest = AW'(dst); br = b; busy = bz;
  endtask

  int stall_cycles;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel0", int'(sel0), 0);
    check("rst_sel1", int'(sel1), 0);
    check("rst_count", int'(cnt), 0);
    reset = 1'b0;

    // ALU chain: add $3 in EX, consumer of $3 in ID, then one unrelated instruction later
    drive(3, 0, 1, 0, 3, 0, 0); cycle();
`ifdef HAZARD_FORWARDING_EN
    check("chain_ex_sel0", int'(sel0), 1);
    drive(3, 0, 1, 0, 7, 0, 0); cycle();
    check("chain_mem_sel0", int'(sel0), 2);
    check("chain_nostall", int'(cnt), 0);
`else
    stall_cycles = 1;
    drive(3, 0, 0, 0, 0, 0, 0); cycle();
    stall_cycles += (m_cnt == 2) ? 1 : 0;
    drive(3, 0, 0, 0, 0, 0, 0); cycle();
    check("chain_stall_cycles", int'(cnt), 2);
    check("chain_sel0_zero", int'(sel0), 0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // Load-use on rt: one stall, then the load sits in MEM
    drive(0, 8, 1, 1, 8, 0, 0); cycle();
    drive(0, 8, 0, 0, 0, 0, 0); cycle();
`ifdef HAZARD_FORWARDING_EN
    check("loaduse_sel1", int'(sel1), 2);
`endif
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // Register $0 never matches
    drive(0, 0, 1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 1, 0, 0, 0); cycle();
    check("zero_sel0", int'(sel0), 0);

    // Flush beats load-use; then freeze beats flush and holds state for 3 cycles
    drive(5, 5, 1, 1, 5, 1, 0); cycle();
    check("flush_sel0", int'(sel0), 0);
    drive(5, 5, 1, 1, 5, 1, 1);
    repeat (3) cycle();

    // Saturation: 20 freeze cycles
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (20) cycle();
    check("sat_count", int'(cnt), CNT_MAX);

    // Async reset mid-freeze, between clock edges
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("async_count", int'(cnt), 0);
    check("async_sel0", int'(sel0), 0);
    check("async_sel1", int'(sel1), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // Random traffic over a small register range to provoke frequent matches
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
